// File: rtl/ram_sp_arbiter.sv
// Two-requester arbiter for a single-port RAM with 1-cycle registered read return.
// Grant is combinational from valids; read data comes back exactly one cycle after issue, no response backpressure.
module ram_sp_arbiter #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int FIXED_PRI = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_wr,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_rdata,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_wr,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_rdata,

    output logic             ram_ce,
    output logic             ram_r_wn,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    logic last_grant;
    logic rd_pend;
    logic rd_id;
    logic grant0;
    logic grant1;

    // On a tie, round-robin favours whoever did not win last; fixed priority always favours requester 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if ((FIXED_PRI != 0) || last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        ram_ce    = 1'b0;
        ram_r_wn  = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant0) begin
            ram_ce    = 1'b1;
            ram_r_wn  = ~req0_wr;
            ram_addr  = req0_addr;
            ram_wdata = req0_wdata;
        end else if (grant1) begin
            ram_ce    = 1'b1;
            ram_r_wn  = ~req1_wr;
            ram_addr  = req1_addr;
            ram_wdata = req1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
            rd_pend    <= ~ram_r_wn ? 1'b0 : 1'b1;
            rd_id      <= grant1;
        end else begin
            rd_pend    <= 1'b0;
        end
    end

    // Both response buses carry the RAM output; only the matching valid qualifies it.
    assign rsp0_valid = rd_pend & ~rd_id;
    assign rsp1_valid = rd_pend &  rd_id;
    assign rsp0_rdata = ram_rdata;
    assign rsp1_rdata = ram_rdata;

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Two-requester arbiter and sequencer for a single-port synchronous RAM. The RAM has a ce/r_wn/addr/wdata/rdata port, 1-cycle registered read, and drives rdata to X when not reading.
- Accepts read/write requests from two clients over valid/ready handshakes and grants at most one access per cycle.
- Drives the RAM port and routes each read result back to the requester that issued it.
- Sits between two masters (e.g. a DMA and a CPU-side port) and one ram_single_port-style instance.

Parameters:
- DEPTH, 16, RAM word count; must be >= 2. AW = $clog2(DEPTH).
- WIDTH, 8, data width in bits.
- FIXED_PRI, 0, 0 = round-robin arbitration; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an access pending.
- req0_ready  output  1  requester 0's access is issued this cycle.
- req0_wr  input  1  1 = write, 0 = read.
- req0_addr  input  AW  word address.
- req0_wdata  input  WIDTH  write data.
- rsp0_valid  output  1  read data for requester 0 is valid this cycle.
- rsp0_rdata  output  WIDTH  read data.
- req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- ram_ce  output  1  RAM chip enable.
- ram_r_wn  output  1  1 = read, 0 = write.
- ram_addr  output  AW  RAM address.
- ram_wdata  output  WIDTH  RAM write data.
- ram_rdata  input  WIDTH  RAM registered read data.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- While rst is high:
  - req0_ready = req1_ready = 0; ram_ce = 0.
  - rsp0_valid = rsp1_valid = 0 in the cycle after any rst-high edge.
  - Internal last_grant <= 1, so requester 0 wins the first tie; rd_pend <= 0.
- Grant (combinational from valid inputs and last_grant):
  - Only one valid: that requester is granted.
  - Both valid, FIXED_PRI = 1: requester 0 is granted.
  - Both valid, FIXED_PRI = 0: the requester not equal to last_grant is granted.
  - reqN_ready = grantN. Transfer occurs when valid && ready in the same cycle.
  - last_grant updates on every transfer; it holds when idle.
- Handshake rules:
  - A requester holds valid and its payload stable until ready.
  - ready never depends on the requester's own payload.
  - No combinational path from reqN_valid to reqN_ready other than the grant logic.
- RAM drive:
  - On a transfer: ram_ce = 1, ram_r_wn = ~reqN_wr, ram_addr/ram_wdata = the granted payload.
  - Idle: ram_ce = 0, ram_r_wn = 1, ram_addr = 0, ram_wdata = 0 (no X on outputs).
- Read return:
  - A read transfer in cycle N sets rd_pend <= 1 and rd_id <= N's grantee.
  - In cycle N+1, rsp<rd_id>_valid = 1 and rsp<rd_id>_rdata = ram_rdata; the other requester's rsp_valid = 0.
  - Latency is exactly 1 cycle; no backpressure on responses.
  - rsp*_rdata is a don't-care when the matching rsp_valid = 0. The bench must not compare it.
- Writes: complete in the transfer cycle; no response; rd_pend <= 0.
- Throughput: one access per cycle. Back-to-back reads from either requester return in consecutive cycles, in issue order.
- Read-after-write to the same address in the next cycle returns the new data.
- Reset mid-operation: a read issued in the cycle rst is sampled high produces no response; rd_pend is cleared.
- A requester deasserting valid without a transfer is a protocol violation; behaviour is undefined. The bench flags it with an assertion.

Test Plan:
- Write then read, single requester: req0 writes 0xA5 to addr 3, then reads addr 3 -> req0_ready high both cycles; rsp0_valid exactly 1 cycle after the read transfer with rdata 0xA5; rsp1_valid stays 0.
- Round-robin contention, FIXED_PRI=0: both requesters continuously read addr 1 (req0) and addr 2 (req1) for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; responses alternate rsp0/rsp1 with the correct data, one per cycle.
- Fixed priority, FIXED_PRI=1: same stimulus -> req0 granted all 6 cycles and req1_ready = 0; req1 granted in the first cycle req0_valid drops.
- Back-to-back read-after-write: req1 writes 0x3C to addr 7, and req0 reads addr 7 in the next cycle -> rsp0_rdata = 0x3C.
- Idle port: no valids for 5 cycles -> ram_ce = 0, ram_addr = 0, ram_wdata = 0, no rsp_valid.
- Reset mid-read: req0 read to addr 5 issued in the same cycle rst is high -> no rsp0_valid in the next cycle; first tie after reset goes to req0.
